mem_stage_dm: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline bundle. It takes the registered ALU result, store data and instruction, and performs the data-memory access.
- Stores sw/sh/sb as byte-enabled read-modify-write into a word array.
- Loads lw/lh/lhu/lb/lbu with sign or zero extension.
- Drives the write-back data toward MEM/WB and a per-store trace bundle for the verification log.

---
 rtl/mem_stage_dm.sv | 138 +++++++++++++
 tb/tb_mem_stage_dm.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage_dm.sv
// MEM-stage data memory: byte-enabled stores as read-modify-write on a word
// array, sign/zero-extended loads, and a per-store trace bundle.
module mem_stage_dm #(
  parameter int DEPTH = 3072,
  parameter int AW    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_Mem,
  input  logic [31:0] instr_Mem,
  input  logic [31:0] aluAns_Mem,
  input  logic [31:0] grfRd2_Mem,
  input  logic [31:0] grfWd_Mem,
  output logic [31:0] dmRd,
  output logic [31:0] grfWd_Out,
  output logic        isLoad,
  output logic        wrEn,
  output logic [31:0] wrAddr,
  output logic [31:0] wrData,
  output logic [31:0] wrPc,
  output logic        addrErr
);

  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_e;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [31:0] mem [DEPTH];

  logic [5:0]    opcode;
  logic          is_load;
  logic          is_store;
  logic          sign_ext;
  size_e         size;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          in_range;
  logic          misaligned;
  logic [31:0]   word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [25:0]   unused_instr;

  assign opcode       = instr_Mem[31:26];
  assign unused_instr = instr_Mem[25:0];
  assign idx          = aluAns_Mem[AW+1:2];
  assign off          = aluAns_Mem[1:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    is_load  = 1'b0;
    is_store = 1'b0;
    sign_ext = 1'b0;
    size     = SZ_WORD;
    unique case (opcode)
      OP_LW:   begin is_load = 1'b1;  size = SZ_WORD; end
      OP_LH:   begin is_load = 1'b1;  size = SZ_HALF; sign_ext = 1'b1; end
      OP_LHU:  begin is_load = 1'b1;  size = SZ_HALF; end
      OP_LB:   begin is_load = 1'b1;  size = SZ_BYTE; sign_ext = 1'b1; end
      OP_LBU:  begin is_load = 1'b1;  size = SZ_BYTE; end
      OP_SW:   begin is_store = 1'b1; size = SZ_WORD; end
      OP_SH:   begin is_store = 1'b1; size = SZ_HALF; end
      OP_SB:   begin is_store = 1'b1; size = SZ_BYTE; end
      default: ;
    endcase
  end

  assign in_range   = (aluAns_Mem[31:AW+2] == '0) && ({1'b0, idx} < DEPTH_W);
  assign misaligned = (size == SZ_WORD && off != 2'b00) ||
                      (size == SZ_HALF && off[0]);
  assign addrErr    = (is_load || is_store) && (!in_range || misaligned);

  // Asynchronous read; misaligned loads use the truncated offset.
  assign word    = in_range ? mem[idx] : 32'h0;
  assign rd_half = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    rd_byte = 8'h00;
    unique case (off)
      2'd0: rd_byte = word[7:0];
      2'd1: rd_byte = word[15:8];
      2'd2: rd_byte = word[23:16];
      2'd3: rd_byte = word[31:24];
    endcase
  end

  always_comb begin
    dmRd = 32'h0;
    if (is_load) begin
      unique case (size)
        SZ_WORD: dmRd = word;
        SZ_HALF: dmRd = {{16{sign_ext & rd_half[15]}}, rd_half};
        SZ_BYTE: dmRd = {{24{sign_ext & rd_byte[7]}}, rd_byte};
        default: dmRd = 32'h0;
      endcase
    end
  end

  // Store merge: untouched bytes keep the current word contents.
  always_comb begin
    wrData = word;
    if (is_store) begin
      unique case (size)
        SZ_WORD: wrData = grfRd2_Mem;
        SZ_HALF: if (off[1]) wrData[31:16] = grfRd2_Mem[15:0];
                 else        wrData[15:0]  = grfRd2_Mem[15:0];
        SZ_BYTE: wrData[8*off +: 8] = grfRd2_Mem[7:0];
        default: wrData = word;
      endcase
    end
  end

  assign isLoad    = is_load;
  assign grfWd_Out = is_load ? dmRd : grfWd_Mem;
  assign wrEn      = is_store && in_range && !misaligned && !reset;
  assign wrAddr    = {aluAns_Mem[31:2], 2'b00};
  assign wrPc      = pc_Mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the whole array is cleared on reset, so it must stay a register
      // file; a RAM macro without a clear port cannot implement this.
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (wrEn) begin
      mem[idx] <= wrData;
    end
  end

endmodule

// File: tb/tb_mem_stage_dm.sv
// Directed self-checking bench for mem_stage_dm: round-trips, merges,
// extension, range/alignment errors and reset behaviour.
module tb_mem_stage_dm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_Mem, instr_Mem, aluAns_Mem, grfRd2_Mem, grfWd_Mem;
  logic [31:0] dmRd, grfWd_Out, wrAddr, wrData, wrPc;
  logic        isLoad, wrEn, addrErr;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101;
  localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100;
  localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;
  localparam logic [5:0] ADDU = 6'b000000;

  mem_stage_dm dut (
    .clk        (clk),
    .reset      (reset),
    .pc_Mem     (pc_Mem),
    .instr_Mem  (instr_Mem),
    .aluAns_Mem (aluAns_Mem),
    .grfRd2_Mem (grfRd2_Mem),
    .grfWd_Mem  (grfWd_Mem),
    .dmRd       (dmRd),
    .grfWd_Out  (grfWd_Out),
    .isLoad     (isLoad),
    .wrEn       (wrEn),
    .wrAddr     (wrAddr),
    .wrData     (wrData),
    .wrPc       (wrPc),
    .addrErr    (addrErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one instruction on the falling edge; outputs settle 1 ns later,
  // and any store commits at the following rising edge.
  task automatic step(input logic rst, input logic [5:0] op, input logic [31:0] addr,
                      input logic [31:0] data);
    @(negedge clk);
    reset      = rst;
    instr_Mem  = {op, 26'h0};
    aluAns_Mem = addr;
    grfRd2_Mem = data;
    grfWd_Mem  = 32'h0000_0077;
    pc_Mem     = pc_Mem + 32'd4;
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    pc_Mem     = 32'h0000_3000;
    instr_Mem  = 32'h0;
    aluAns_Mem = 32'h0;
    grfRd2_Mem = 32'h0;
    grfWd_Mem  = 32'h0;

    // Store issued during reset must not commit
    step(1'b1, SW, 32'h10, 32'h1111_1111);
    check("rst_wren", {31'b0, wrEn}, 32'd0);

    // Word round-trip
    step(1'b0, SW, 32'h10, 32'h1234_5678);
    check("sw_wren", {31'b0, wrEn}, 32'd1);
    check("sw_wraddr", wrAddr, 32'h10);
    check("sw_wrdata", wrData, 32'h1234_5678);
    check("sw_wrpc", wrPc, 32'h0000_3008);
    check("sw_isload", {31'b0, isLoad}, 32'd0);
    check("sw_grfwd", grfWd_Out, 32'h77);
    step(1'b0, LW, 32'h10, 32'h0);
    check("lw_dmrd", dmRd, 32'h1234_5678);
    check("lw_grfwd", grfWd_Out, 32'h1234_5678);
    check("lw_isload", {31'b0, isLoad}, 32'd1);
    check("lw_wren", {31'b0, wrEn}, 32'd0);

    // Byte merge; upper store-data bits must be ignored
    step(1'b0, SB, 32'h11, 32'hFFFF_FFAB);
    check("sb_wrdata", wrData, 32'h1234_AB78);
    check("sb_wraddr", wrAddr, 32'h10);
    step(1'b0, LB, 32'h11, 32'h0);
    check("lb_dmrd", dmRd, 32'hFFFF_FFAB);
    step(1'b0, LBU, 32'h11, 32'h0);
    check("lbu_dmrd", dmRd, 32'h0000_00AB);
    step(1'b0, LBU, 32'h13, 32'h0);
    check("lbu3_dmrd", dmRd, 32'h0000_0012);

    // Half merge
    step(1'b0, SH, 32'h12, 32'h1234_8001);
    check("sh_wrdata", wrData, 32'h8001_AB78);
    check("sh_wren", {31'b0, wrEn}, 32'd1);
    step(1'b0, LH, 32'h12, 32'h0);
    check("lh_dmrd", dmRd, 32'hFFFF_8001);
    step(1'b0, LHU, 32'h12, 32'h0);
    check("lhu_dmrd", dmRd, 32'h0000_8001);
    step(1'b0, LH, 32'h10, 32'h0);
    check("lh_lo_dmrd", dmRd, 32'hFFFF_AB78);

    // Last word commits
    step(1'b0, SW, 32'h2FFC, 32'hCAFE_F00D);
    check("last_wren", {31'b0, wrEn}, 32'd1);
    check("last_err", {31'b0, addrErr}, 32'd0);
    step(1'b0, LW, 32'h2FFC, 32'h0);
    check("last_lw", dmRd, 32'hCAFE_F00D);

    // One past the end: dropped
    step(1'b0, SW, 32'h3000, 32'hDEAD_BEEF);
    check("oor_err", {31'b0, addrErr}, 32'd1);
    check("oor_wren", {31'b0, wrEn}, 32'd0);
    step(1'b0, LW, 32'h3000, 32'h0);
    check("oor_lw", dmRd, 32'h0);
    check("oor_lw_err", {31'b0, addrErr}, 32'd1);
    step(1'b0, LW, 32'h2FFC, 32'h0);
    check("oor_unchanged", dmRd, 32'hCAFE_F00D);

    // High address bits set: must not alias onto word 0x10
    step(1'b0, SW, 32'h0001_0010, 32'hDEAD_BEEF);
    check("hi_err", {31'b0, addrErr}, 32'd1);
    check("hi_wren", {31'b0, wrEn}, 32'd0);
    step(1'b0, LW, 32'h10, 32'h0);
    check("hi_unchanged", dmRd, 32'h8001_AB78);

    // Misaligned store dropped; misaligned loads flag but return data
    step(1'b0, SH, 32'h11, 32'h0000_5555);
    check("mis_sh_err", {31'b0, addrErr}, 32'd1);
    check("mis_sh_wren", {31'b0, wrEn}, 32'd0);
    step(1'b0, LW, 32'h12, 32'h0);
    check("mis_lw_err", {31'b0, addrErr}, 32'd1);
    check("mis_lw_dmrd", dmRd, 32'h8001_AB78);
    step(1'b0, LH, 32'h13, 32'h0);
    check("mis_lh_dmrd", dmRd, 32'hFFFF_8001);
    step(1'b0, LB, 32'h13, 32'h0);
    check("lb_aligned_err", {31'b0, addrErr}, 32'd0);

    // Back-to-back byte stores to one word
    step(1'b0, SB, 32'h24, 32'h0000_0011);
    check("b2b_sb0", wrData, 32'h0000_0011);
    step(1'b0, SB, 32'h25, 32'h0000_0022);
    check("b2b_sb1", wrData, 32'h0000_2211);
    step(1'b0, LW, 32'h24, 32'h0);
    check("b2b_lw", dmRd, 32'h0000_2211);

    // Reset in the same cycle as a store
    step(1'b1, SW, 32'h20, 32'hFFFF_FFFF);
    check("rst_sw_wren", {31'b0, wrEn}, 32'd0);
    step(1'b0, LW, 32'h20, 32'h0);
    check("rst_lw20", dmRd, 32'h0);
    step(1'b0, LW, 32'h10, 32'h0);
    check("rst_lw10", dmRd, 32'h0);
    step(1'b0, LW, 32'h24, 32'h0);
    check("rst_lw24", dmRd, 32'h0);

    // Non-memory instruction
    @(negedge clk);
    instr_Mem  = {ADDU, 26'h0};
    aluAns_Mem = 32'h3001;
    grfWd_Mem  = 32'h55;
    #1;
    check("alu_isload", {31'b0, isLoad}, 32'd0);
    check("alu_wren", {31'b0, wrEn}, 32'd0);
    check("alu_err", {31'b0, addrErr}, 32'd0);
    check("alu_dmrd", dmRd, 32'h0);
    check("alu_grfwd", grfWd_Out, 32'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
